// File: rtl/crc_hamming_corrector.sv
// Purpose : receive-side CRC check; bit-serial division forms the syndrome, then a
//           position search flips the single bit whose x^i mod GEN matches it.
// Latency : N+M-1 divide cycles, plus k+1 locate cycles for an error at bit k.
// Backpressure: one codeword in flight; in_ready only in IDLE, result held in DONE
//           until out_ready.
// Ports   : clk/rst (sync, active-high); data_in/in_valid/in_ready codeword input;
//           data_out/syndrome/error_detected/error_corrected/error_pos/out_valid/
//           out_ready result output.
module crc_hamming_corrector #(
    parameter int             N   = 11,
    parameter int             M   = 5,
    parameter logic [M-1:0]   GEN = 5'b10011
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N+M-2:0]              data_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [N-1:0]                data_out,
    output logic [M-2:0]                syndrome,
    output logic                        error_detected,
    output logic                        error_corrected,
    output logic [$clog2(N+M-1)-1:0]    error_pos,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int CW = N + M - 1;        // codeword width
    localparam int R  = M - 1;            // CRC / syndrome width
    localparam int PW = $clog2(CW);       // bit-index width

    // Generator without its implicit x^(M-1) term: the feedback taps.
    localparam logic [R-1:0]  POLY = GEN[R-1:0];
    localparam logic [PW-1:0] LAST = PW'(CW - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        LOCATE,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [CW-1:0]  cw;        // captured codeword, corrected in place
    logic [R-1:0]   rem;       // running remainder during division
    logic [R-1:0]   p;         // x^cnt mod GEN during the search
    logic [PW-1:0]  cnt;       // bit counter (divide) / candidate position (locate)

    logic           cur_bit;
    logic [R-1:0]   rem_nxt;
    logic [R-1:0]   p_nxt;
    logic           last_step;
    logic           hit;

    // Division consumes the codeword MSB first, so the bit index counts down.
    assign cur_bit   = cw[LAST - cnt];
    assign rem_nxt   = {rem[R-2:0], cur_bit} ^ (rem[R-1] ? POLY : '0);
    assign p_nxt     = {p[R-2:0], 1'b0} ^ (p[R-1] ? POLY : '0);
    assign last_step = (cnt == LAST);
    assign hit       = (p == syndrome);

    assign in_ready       = (state == IDLE);
    assign out_valid      = (state == DONE);
    assign data_out       = cw[CW-1:R];
    assign error_detected = |syndrome;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = DIVIDE;
                end
            end
            DIVIDE: begin
                if (last_step) begin
                    state_nxt = (rem_nxt == '0) ? DONE : LOCATE;
                end
            end
            LOCATE: begin
                // A match on the final candidate still counts as a correction.
                if (hit || last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cw              <= '0;
            rem             <= '0;
            p               <= '0;
            cnt             <= '0;
            syndrome        <= '0;
            error_corrected <= 1'b0;
            error_pos       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cw  <= data_in;
                        rem <= '0;
                        cnt <= '0;
                    end
                end
                DIVIDE: begin
                    rem <= rem_nxt;
                    if (last_step) begin
                        // Search starts at bit 0 whose residue is x^0 = 1.
                        syndrome        <= rem_nxt;
                        cnt             <= '0;
                        p               <= R'(1);
                        error_corrected <= 1'b0;
                        error_pos       <= '0;
                    end else begin
                        cnt <= cnt + PW'(1);
                    end
                end
                LOCATE: begin
                    if (hit) begin
                        error_pos       <= cnt;
                        error_corrected <= 1'b1;
                        cw              <= cw ^ (CW'(1) << cnt);
                    end else if (last_step) begin
                        error_corrected <= 1'b0;
                        error_pos       <= '0;
                    end else begin
                        p   <= p_nxt;
                        cnt <= cnt + PW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_hamming_corrector.sv
// Purpose : directed bench for crc_hamming_corrector with a result scoreboard.
// Latency : expected latency counted as the edge at which the sink first sees out_valid.
// Backpressure: exercises held out_ready, ignored in_valid and mid-flight resets.
module tb_crc_hamming_corrector;

    typedef struct {
        logic [10:0] dat;
        logic [3:0]  syn;
        logic        det;
        logic        cor;
        logic [3:0]  pos;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] din;
    logic        ivld;
    logic        ordy;
    logic        sel;          // 0: default-GEN DUT, 1: GEN=11111 DUT

    logic        d_irdy, g_irdy, d_ovld, g_ovld;
    logic [10:0] d_dout, g_dout;
    logic [3:0]  d_syn, g_syn, d_pos, g_pos;
    logic        d_det, g_det, d_cor, g_cor;

    logic        m_irdy, m_ovld, m_det, m_cor;
    logic [10:0] m_dout;
    logic [3:0]  m_syn, m_pos;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    crc_hamming_corrector dut (
        .clk(clk), .rst(rst), .data_in(din), .in_valid(ivld & ~sel), .in_ready(d_irdy),
        .data_out(d_dout), .syndrome(d_syn), .error_detected(d_det),
        .error_corrected(d_cor), .error_pos(d_pos), .out_valid(d_ovld), .out_ready(ordy)
    );

    crc_hamming_corrector #(.N(11), .M(5), .GEN(5'b11111)) dut_g (
        .clk(clk), .rst(rst), .data_in(din), .in_valid(ivld & sel), .in_ready(g_irdy),
        .data_out(g_dout), .syndrome(g_syn), .error_detected(g_det),
        .error_corrected(g_cor), .error_pos(g_pos), .out_valid(g_ovld), .out_ready(ordy)
    );

    assign m_irdy = sel ? g_irdy : d_irdy;
    assign m_ovld = sel ? g_ovld : d_ovld;
    assign m_dout = sel ? g_dout : d_dout;
    assign m_syn  = sel ? g_syn  : d_syn;
    assign m_det  = sel ? g_det  : d_det;
    assign m_cor  = sel ? g_cor  : d_cor;
    assign m_pos  = sel ? g_pos  : d_pos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [10:0] dat, input logic [3:0] syn,
                                input logic det, input logic cor,
                                input logic [3:0] pos, input int lat);
        exp_t e;
        e.dat = dat; e.syn = syn; e.det = det; e.cor = cor; e.pos = pos; e.lat = lat;
        return e;
    endfunction

    // Complete the output handshake; in_ready must be back right after edge D.
    task automatic recv(input string tag);
        ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy = 1'b0;
        chk({tag, "_irdy_after"}, 32'(m_irdy), 32'd1);
        chk({tag, "_ovld_after"}, 32'(m_ovld), 32'd0);
    endtask

    // Starts and ends on a falling edge.
    task automatic xact(input string tag, input logic [14:0] w, input exp_t e,
                        input bit release_now);
        exp_t got;
        int   edges;
        bit   acc;
        din  = w;
        ivld = 1'b1;
        acc  = 1'b0;
        for (int n = 0; n < 40 && !acc; n++) begin
            if (m_irdy) acc = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        ivld = 1'b0;
        chk({tag, "_accept"}, 32'(acc), 32'd1);
        if (acc) sbq.push_back(e);
        edges = 0;
        while (!m_ovld && edges < 60) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk({tag, "_ovld_seen"}, 32'(m_ovld), 32'd1);
        if (m_ovld && sbq.size() > 0) begin
            got = sbq.pop_front();
            chk({tag, "_data_out"}, 32'(m_dout), 32'(got.dat));
            chk({tag, "_syndrome"}, 32'(m_syn), 32'(got.syn));
            chk({tag, "_detected"}, 32'(m_det), 32'(got.det));
            chk({tag, "_corrected"}, 32'(m_cor), 32'(got.cor));
            chk({tag, "_pos"}, 32'(m_pos), 32'(got.pos));
            chk({tag, "_latency"}, 32'(edges + 1), 32'(got.lat));
        end
        if (release_now) recv(tag);
    endtask

    // Accept a word, let it run 'cycles' edges, then pulse reset for one edge.
    task automatic abort(input string tag, input logic [14:0] w, input int cycles);
        int seen;
        din  = w;
        ivld = 1'b1;
        chk({tag, "_irdy_before"}, 32'(m_irdy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        ivld = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk({tag, "_irdy_next"}, 32'(m_irdy), 32'd1);
        chk({tag, "_ovld_next"}, 32'(m_ovld), 32'd0);
        chk({tag, "_syn_cleared"}, 32'(m_syn), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (m_ovld) seen++;
        end
        chk({tag, "_no_ovld"}, 32'(seen), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        ivld = 1'b0;
        ordy = 1'b0;
        sel  = 1'b0;
        din  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_in_ready", 32'(d_irdy), 32'd1);
        chk("rst_out_valid", 32'(d_ovld), 32'd0);
        chk("rst_data_out", 32'(d_dout), 32'd0);
        chk("rst_syndrome", 32'(d_syn), 32'd0);
        chk("rst_detected", 32'(d_det), 32'd0);
        chk("rst_corrected", 32'(d_cor), 32'd0);
        chk("rst_pos", 32'(d_pos), 32'd0);

        xact("clean001", 15'h0013, mk(11'h001, 4'h0, 1'b0, 1'b0, 4'd0, 16), 1'b1);
        xact("bit7",     15'h0093, mk(11'h001, 4'hB, 1'b1, 1'b1, 4'd7, 24), 1'b1);
        xact("ones",     15'h7FFF, mk(11'h7FF, 4'h0, 1'b0, 1'b0, 4'd0, 16), 1'b1);
        xact("ones_b0",  15'h7FFE, mk(11'h7FF, 4'h1, 1'b1, 1'b1, 4'd0, 17), 1'b1);
        xact("ones_b14", 15'h3FFF, mk(11'h7FF, 4'h9, 1'b1, 1'b1, 4'd14, 31), 1'b1);

        sel = 1'b1;
        xact("uncorr",   15'h0003, mk(11'h000, 4'h3, 1'b1, 1'b0, 4'd0, 31), 1'b1);
        sel = 1'b0;

        // Backpressure: result held, a competing word offered and ignored.
        xact("bp", 15'h0013, mk(11'h001, 4'h0, 1'b0, 1'b0, 4'd0, 16), 1'b0);
        din  = 15'h7FFF;
        ivld = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_ovld_held", 32'(m_ovld), 32'd1);
            chk("bp_irdy_low", 32'(m_irdy), 32'd0);
            chk("bp_dout_stable", 32'(m_dout), 32'h001);
            chk("bp_syn_stable", 32'(m_syn), 32'h0);
        end
        ivld = 1'b0;
        recv("bp");
        xact("after_bp", 15'h0093, mk(11'h001, 4'hB, 1'b1, 1'b1, 4'd7, 24), 1'b1);

        abort("rst_divide", 15'h0093, 5);
        abort("rst_locate", 15'h3FFF, 20);
        xact("after_rst", 15'h0093, mk(11'h001, 4'hB, 1'b1, 1'b1, 4'd7, 24), 1'b1);

        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
